// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs_pkg
// Description : Shared definitions for the 4-bit LFSR pattern generator and
//               checker: checker state enum, LFSR step function (polynomial
//               x^4+x^3+1, period 15), 4-bit popcount and the generator seed.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LFSR4_SEED = 4'b1111;

    // One LFSR step; the all-zero word maps to itself (lock-up state).
    function automatic logic [3:0] lfsr4_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_accum.sv
`default_nettype none
// ============================================================================
// Module      : sat_accum
// Description : CNT_W-bit saturating accumulator. Adds a 3-bit increment when
//               add_en is high and clamps at all-ones; clear has priority.
// Ports       : clk     - clock, rising edge
//               reset   - synchronous, active-low reset
//               clear   - synchronous clear to zero (priority over add)
//               add_en  - add inc this cycle
//               inc     - increment value (0..7)
//               cnt     - accumulated value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_accum #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             add_en,
    input  logic [2:0]       inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_sum;

    // One extra bit catches the carry out so the add can clamp instead of wrap.
    assign w_sum = {1'b0, r_cnt} + {{(CNT_W-2){1'b0}}, inc};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (add_en) begin
            r_cnt <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/prbs4_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs4_checker
// Description : Self-synchronising checker for the 4-bit LFSR word stream.
//               Hunts for a nonzero seed, verifies LOCK_CNT following words,
//               then flywheels while locked, counting word and bit errors.
//               Lock drops after LOSS_CNT consecutive bad words.
// Ports       : clk          - clock, rising edge
//               reset        - synchronous, active-low reset
//               in_valid     - in_data carries a received word this cycle
//               in_data      - received 4-bit LFSR word
//               clear_errs   - synchronous clear of both error counters
//               locked       - high while in LOCKED
//               err_pulse    - one cycle: previous accepted word mismatched
//               word_err_cnt - saturating count of bad words while locked
//               bit_err_cnt  - saturating sum of bad bits while locked
// Revision    : 1.0 - initial release
// ============================================================================
module prbs4_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             clear_errs,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] word_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt
);

    // run_cnt must hold values up to the larger of the two thresholds.
    localparam int c_RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int c_RUN_W   = $clog2(c_RUN_MAX + 1);
    localparam logic [c_RUN_W-1:0] c_LOCK_LAST = c_RUN_W'(LOCK_CNT - 1);
    localparam logic [c_RUN_W-1:0] c_LOSS_LAST = c_RUN_W'(LOSS_CNT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_expected;
    logic [3:0]         w_expected_nxt;
    logic [c_RUN_W-1:0] r_run_cnt;
    logic [c_RUN_W-1:0] w_run_nxt;
    logic               r_locked;
    logic               r_err_pulse;
    logic               w_err;
    logic               w_match;
    logic [3:0]         w_seed_nxt;
    logic [3:0]         w_fly_nxt;
    logic [2:0]         w_bit_errs;

    assign w_match    = (in_data == r_expected);
    assign w_seed_nxt = lfsr4_next(in_data);
    assign w_fly_nxt  = lfsr4_next(r_expected);
    assign w_bit_errs = popcount4(in_data ^ r_expected);

    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_run_nxt      = r_run_cnt;
        w_err          = 1'b0;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    // A zero word cannot seed: the LFSR never leaves zero.
                    if (in_data != 4'd0) begin
                        w_expected_nxt = w_seed_nxt;
                        w_run_nxt      = '0;
                        w_state_nxt    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_match) begin
                        w_expected_nxt = w_fly_nxt;
                        if (r_run_cnt == c_LOCK_LAST) begin
                            w_run_nxt   = '0;
                            w_state_nxt = LOCKED;
                        end else begin
                            w_run_nxt = r_run_cnt + 1'b1;
                        end
                    end else if (in_data != 4'd0) begin
                        w_expected_nxt = w_seed_nxt;
                        w_run_nxt      = '0;
                    end else begin
                        w_state_nxt = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: once locked, never reseed from received data.
                    w_expected_nxt = w_fly_nxt;
                    if (w_match) begin
                        w_run_nxt = '0;
                    end else begin
                        w_err     = 1'b1;
                        w_run_nxt = r_run_cnt + 1'b1;
                        if (r_run_cnt == c_LOSS_LAST) begin
                            w_state_nxt = HUNT;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= HUNT;
            r_expected  <= 4'd0;
            r_run_cnt   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_expected  <= w_expected_nxt;
            r_run_cnt   <= w_run_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_err;
        end
    end

    sat_accum #(
        .CNT_W (CNT_W)
    ) u_word_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_errs),
        .add_en (w_err),
        .inc    (3'd1),
        .cnt    (word_err_cnt)
    );

    sat_accum #(
        .CNT_W (CNT_W)
    ) u_bit_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_errs),
        .add_en (w_err),
        .inc    (w_bit_errs),
        .cnt    (bit_err_cnt)
    );

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_prbs4_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs4_checker
// Description : Scoreboard bench for prbs4_checker. Two instances (CNT_W=16
//               and CNT_W=4) see identical stimulus; a reference model built
//               on the 15-entry LFSR sequence table predicts every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs4_checker;

    localparam int c_LOCK = 4;
    localparam int c_LOSS = 3;
    localparam int c_WA   = 16;
    localparam int c_WB   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      = 1'b0;
    logic        in_valid   = 1'b0;
    logic [3:0]  in_data    = 4'd0;
    logic        clear_errs = 1'b0;

    logic        a_locked, a_err;
    logic [15:0] a_wcnt, a_bcnt;
    logic        b_locked, b_err;
    logic [3:0]  b_wcnt, b_bcnt;

    prbs4_checker #(.LOCK_CNT(c_LOCK), .LOSS_CNT(c_LOSS), .CNT_W(c_WA)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .clear_errs(clear_errs), .locked(a_locked), .err_pulse(a_err),
        .word_err_cnt(a_wcnt), .bit_err_cnt(a_bcnt)
    );

    prbs4_checker #(.LOCK_CNT(c_LOCK), .LOSS_CNT(c_LOSS), .CNT_W(c_WB)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .clear_errs(clear_errs), .locked(b_locked), .err_pulse(b_err),
        .word_err_cnt(b_wcnt), .bit_err_cnt(b_bcnt)
    );

    // The generator's output sequence starting from 1111.
    logic [3:0] seq [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                             4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

    typedef struct {
        int lck;
        int err;
        int wa, ba, wb, bb;
    } exp_t;
    exp_t q[$];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: position in the sequence plus lock bookkeeping.
    bit m_sync = 0, m_lock = 0;
    int m_pos = 0, m_good = 0, m_bad_run = 0;
    int m_wa = 0, m_ba = 0, m_wb = 0, m_bb = 0;
    int src = 0;

    function automatic int idx_of(input logic [3:0] d);
        for (int i = 0; i < 15; i++) if (seq[i] == d) return i;
        return 0;
    endfunction

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst_n, input bit v, input logic [3:0] d, input bit clr);
        exp_t e;
        bit   err;
        int   pc;
        @(negedge clk);
        reset = rst_n; in_valid = v; in_data = d; clear_errs = clr;
        err = 0;
        if (!rst_n) begin
            m_sync = 0; m_lock = 0; m_pos = 0; m_good = 0; m_bad_run = 0;
            m_wa = 0; m_ba = 0; m_wb = 0; m_bb = 0;
        end else begin
            if (v) begin
                if (!m_sync) begin
                    if (d != 4'd0) begin
                        m_pos = (idx_of(d) + 1) % 15; m_good = 0; m_sync = 1;
                    end
                end else if (!m_lock) begin
                    if (d == seq[m_pos]) begin
                        m_pos = (m_pos + 1) % 15;
                        m_good++;
                        if (m_good == c_LOCK) begin m_lock = 1; m_bad_run = 0; end
                    end else if (d != 4'd0) begin
                        m_pos = (idx_of(d) + 1) % 15; m_good = 0;
                    end else begin
                        m_sync = 0;
                    end
                end else begin
                    if (d == seq[m_pos]) begin
                        m_bad_run = 0;
                    end else begin
                        err = 1;
                        pc  = $countones(d ^ seq[m_pos]);
                        m_wa = sat(m_wa + 1, c_WA); m_ba = sat(m_ba + pc, c_WA);
                        m_wb = sat(m_wb + 1, c_WB); m_bb = sat(m_bb + pc, c_WB);
                        m_bad_run++;
                        if (m_bad_run == c_LOSS) begin m_lock = 0; m_sync = 0; end
                    end
                    m_pos = (m_pos + 1) % 15;
                end
            end
            if (clr) begin m_wa = 0; m_ba = 0; m_wb = 0; m_bb = 0; end
        end
        e.lck = m_lock; e.err = err;
        e.wa = m_wa; e.ba = m_ba; e.wb = m_wb; e.bb = m_bb;
        q.push_back(e);
    endtask

    // Waits past the edge that samples the last stepped inputs.
    task automatic after_edge();
        @(posedge clk); #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_a_locked", a_locked, e.lck);
                chk("sb_a_err",    a_err,    e.err);
                chk("sb_a_wcnt",   a_wcnt,   e.wa);
                chk("sb_a_bcnt",   a_bcnt,   e.ba);
                chk("sb_b_locked", b_locked, e.lck);
                chk("sb_b_err",    b_err,    e.err);
                chk("sb_b_wcnt",   b_wcnt,   e.wb);
                chk("sb_b_bcnt",   b_bcnt,   e.bb);
            end
        end
    end

    initial begin : stim
        int nvalid;
        logic [3:0] w4;
        // Reset state
        repeat (3) step(0, 0, 4'd0, 0);
        after_edge();
        chk("rst_locked", a_locked, 0);
        chk("rst_wcnt", a_wcnt, 0);

        // Lock on five consecutive words
        foreach (seq[i]) if (i < 5) step(1, 1, seq[i], 0);
        after_edge();
        chk("lock5_a", a_locked, 1);
        chk("lock5_b", b_locked, 1);
        chk("lock5_wcnt", a_wcnt, 0);

        // Single bad word (expecting 0010), then a good one
        step(1, 1, 4'b0000, 0);
        after_edge();
        chk("err1_pulse", a_err, 1);
        chk("err1_wcnt", a_wcnt, 1);
        chk("err1_bcnt", a_bcnt, 1);
        step(1, 1, 4'b0100, 0);
        after_edge();
        chk("err1_pulse_low", a_err, 0);
        chk("err1_still_locked", a_locked, 1);

        // Three bad words drop lock, then relock from 1001
        step(1, 0, 4'd0, 1);
        repeat (3) step(1, 1, 4'b0000, 0);
        after_edge();
        chk("loss_locked", a_locked, 0);
        chk("loss_wcnt", a_wcnt, 3);
        step(1, 1, 4'b1001, 0); step(1, 1, 4'b0011, 0); step(1, 1, 4'b0110, 0);
        step(1, 1, 4'b1101, 0); step(1, 1, 4'b1010, 0);
        after_edge();
        chk("relock", a_locked, 1);

        // HUNT ignores zeros; 0101 reseeds VERIFY
        step(0, 0, 4'd0, 0);
        step(1, 1, 4'h0, 0); step(1, 1, 4'h0, 0);
        step(1, 1, 4'hF, 0); step(1, 1, 4'hE, 0); step(1, 1, 4'h5, 0);
        step(1, 1, 4'hB, 0); step(1, 1, 4'h7, 0); step(1, 1, 4'hF, 0);
        after_edge();
        chk("reseed_not_yet", a_locked, 0);
        step(1, 1, 4'hE, 0);
        after_edge();
        chk("reseed_locked", a_locked, 1);

        // Clean stream with random gaps: lock after the 5th valid word
        step(0, 0, 4'd0, 0);
        src = $urandom_range(0, 14);
        nvalid = 0;
        while (nvalid < 12) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1, 0, 4'($urandom_range(0, 15)), 0);
            end else begin
                step(1, 1, seq[src], 0);
                src = (src + 1) % 15;
                nvalid++;
            end
            after_edge();
            chk("gap_lock", a_locked, (nvalid >= 5) ? 1 : 0);
        end
        step(1, 1, seq[src] ^ 4'h1, 0); src = (src + 1) % 15;
        step(1, 1, seq[src] ^ 4'h6, 1); src = (src + 1) % 15;
        after_edge();
        chk("clr_err_pulse", a_err, 1);
        chk("clr_wcnt", a_wcnt, 0);
        chk("clr_bcnt", a_bcnt, 0);
        step(1, 1, seq[src], 0); src = (src + 1) % 15;

        // Saturation on the narrow instance: 20 good/all-flipped pairs
        step(0, 0, 4'd0, 0);
        src = $urandom_range(0, 14);
        repeat (5) begin step(1, 1, seq[src], 0); src = (src + 1) % 15; end
        for (int i = 0; i < 20; i++) begin
            step(1, 1, seq[src], 0); src = (src + 1) % 15;
            step(1, 1, ~seq[src], 0); src = (src + 1) % 15;
            if (i == 3) begin
                after_edge();
                chk("sat_bcnt_4th", b_bcnt, 15);
            end
        end
        after_edge();
        chk("sat_b_wcnt", b_wcnt, 15);
        chk("sat_b_bcnt", b_bcnt, 15);
        chk("sat_b_locked", b_locked, 1);
        chk("sat_a_wcnt", a_wcnt, 20);
        chk("sat_a_bcnt", a_bcnt, 80);
        step(0, 1, seq[src], 0);
        after_edge();
        chk("midrst_locked", a_locked, 0);
        chk("midrst_err", b_err, 0);
        chk("midrst_wcnt", b_wcnt, 0);
        chk("midrst_bcnt", a_bcnt, 0);

        // Randomised traffic against the model
        src = $urandom_range(0, 14);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                step(0, 0, 4'd0, 0);
            end else if ($urandom_range(0, 4) == 0) begin
                step(1, 0, 4'($urandom_range(0, 15)), ($urandom_range(0, 49) == 0));
            end else begin
                w4 = seq[src];
                if ($urandom_range(0, 9) == 0) w4 = 4'($urandom_range(0, 15));
                step(1, 1, w4, ($urandom_range(0, 49) == 0));
                src = (src + 1) % 15;
            end
        end

        step(1, 0, 4'd0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain queue_left=%0d expected=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs4_checker.md
# prbs4_checker

Receive-side companion to the team's 4-bit LFSR pattern generator. Accepts the parallel 4-bit word stream (polynomial x^4+x^3+1, next = {s[2:0], s[3]^s[2]}, period 15), self-synchronises to it, and reports lock status plus word- and bit-error counts. Sits at the far end of the link or loopback under test, one word per valid cycle.

## Interface

- `LOCK_CNT`, default 4: consecutive matching words after the seed that are required to declare lock.
- `LOSS_CNT`, default 3: consecutive mismatching words while locked that drop lock.
- `CNT_W`, default 16: width of the saturating error counters.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset. When 0 at a rising edge, the block resets.
- `in_valid`  in  1  `in_data` is a received word this cycle.
- `in_data`  in  4  received LFSR word.
- `clear_errs`  in  1  synchronous clear of both error counters.
- `locked`  out  1  1 while in LOCKED.
- `err_pulse`  out  1  one-cycle flag: the previous accepted word mismatched while LOCKED.
- `word_err_cnt`  out  CNT_W  count of mismatching words while LOCKED; saturates at all-ones.
- `bit_err_cnt`  out  CNT_W  sum of popcount(in_data ^ expected) over mismatches while LOCKED; saturates.

## Operation

- State machine has three states: HUNT, VERIFY, LOCKED. Internal registers: `expected[3:0]`, `run_cnt`.
- Reset applies when `reset`=0 at an edge: state HUNT, `expected`=0, `run_cnt`=0, `locked`=0, `err_pulse`=0, both counters 0.
- Cycles with `in_valid`=0 do not change state, `expected`, `run_cnt`, or counters. `err_pulse` goes to 0.
- **HUNT**, valid word:
  - `in_data`≠0: `expected`←next(`in_data`), `run_cnt`←0, go to VERIFY.
  - `in_data`=0 (the LFSR lock-up state): stay in HUNT.
- **VERIFY**, valid word:
  - Match: `expected`←next(`expected`), `run_cnt`++. If `run_cnt`=LOCK_CNT-1, go to LOCKED and set `run_cnt`←0.
  - Mismatch with nonzero `in_data`: reseed with `expected`←next(`in_data`), `run_cnt`←0, stay in VERIFY.
  - Mismatch with `in_data`=0: go to HUNT.
  - No counting occurs in this state.
- **LOCKED**, valid word: `expected`←next(`expected`) always; the block flywheels and never reseeds from data.
  - Match: `run_cnt`←0.
  - Mismatch: `err_pulse`←1, `word_err_cnt`+1 (saturating), `bit_err_cnt`+popcount (saturating, clamped when the sum overflows), `run_cnt`++. If `run_cnt`=LOSS_CNT-1, go to HUNT.
- `clear_errs`=1 zeroes both counters and takes priority. An error in the same cycle is not counted, but `err_pulse` still asserts. `clear_errs` does not affect state.
- Reset taken mid-operation (any state) returns all registers to reset values at that edge.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- Lock latency: the seed word plus LOCK_CNT matching valid words. `locked` rises in the cycle after the edge that samples the last of them. With the default LOCK_CNT, that is 5 valid words.
- Error latency: `err_pulse`, `word_err_cnt` and `bit_err_cnt` update in the cycle after the edge that samples the bad word.
- Loss: `locked` falls in the cycle after the LOSS_CNT-th consecutive bad word. That word is counted.
- Gaps in `in_valid` are transparent: the same stream with idle cycles inserted gives identical results.

## Structure

- Shared package `prbs_pkg` holds:
  - the state enum (HUNT/VERIFY/LOCKED);
  - the function `lfsr4_next(s) = {s[2:0], s[3]^s[2]}`, which the generator also uses;
  - `popcount4`;
  - constant `LFSR4_SEED = 4'b1111`.
- One sub-module, `sat_accum`: a CNT_W saturating accumulator with clear, add-enable and a 3-bit increment. It is instantiated twice, with increment 1 and with the popcount.

## Test plan

- Reset, then feed 1111,1110,1100,1000,0001 on consecutive cycles -> `locked`=1 in the cycle after 0001; both counters 0.
- While locked and expecting 0010, send 0000, then 0100 -> `err_pulse`=1 for exactly one cycle, `word_err_cnt`=1, `bit_err_cnt`=1, `locked` stays 1.
- While locked, send three bad words in a row (0000 each) -> `locked`=0 after the third, `word_err_cnt`=3. Then send 1001,0011,0110,1101,1010 -> relocked.
- In HUNT, send 0000 twice (state stays HUNT), then 1111,1110,0101,1011,0111,1111,1110. The 0101 reseeds VERIFY -> `locked`=1 after the final 1110.
- Insert random `in_valid`=0 gaps into a clean stream -> lock timing in valid words is unchanged and there are no errors. Assert `clear_errs` on the same cycle as a bad word -> counters read 0 and `err_pulse`=1.
- With CNT_W=4, alternate good words with words that have all 4 bits flipped, over 20 pairs -> `bit_err_cnt` saturates at 15 after the 4th bad word, `word_err_cnt` saturates at 15, `locked` stays 1. Drive `reset`=0 mid-stream -> all outputs 0 next cycle.
